// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, auxiliary and RAM-side signals around the data-memory
// port arbiter. The slave view belongs to the arbiter; the master view
// belongs to the environment (core, aux requester and RAM).
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  core_en;
  logic [3:0]            core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [31:0]           core_din;
  logic                  core_stall;
  logic                  core_rvalid;

  logic                  aux_req;
  logic [3:0]            aux_we;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic [31:0]           aux_din;
  logic                  aux_gnt;
  logic                  aux_rvalid;
  logic [31:0]           aux_rdata;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [31:0]           ram_dout;

  modport slave (
    input  core_en, core_we, core_addr, core_din,
    output core_stall, core_rvalid,
    input  aux_req, aux_we, aux_addr, aux_din,
    output aux_gnt, aux_rvalid, aux_rdata,
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output core_en, core_we, core_addr, core_din,
    input  core_stall, core_rvalid,
    output aux_req, aux_we, aux_addr, aux_din,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the core owns the single RAM port by default,
// an auxiliary requester gets it when the core is idle, and a starvation
// counter forces a one-cycle aux grant (stalling the core) after
// STARVE_LIMIT blocked cycles. Read data returns with the RAM's 1-cycle
// latency, steered to whichever side issued the read.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      wait_cnt;
  logic                  rd_pend;
  logic                  rd_owner;       // 1: pending read belongs to aux
  logic [31:0]           aux_rdata_hold;

  logic                  contend;
  logic                  forced;
  logic                  aux_own;
  logic                  rd_issue;
  logic                  aux_rvalid;
  logic [3:0]            sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_din;

  // Owner selection and RAM port steering for the current cycle.
  always_comb begin
    contend  = bus.core_en & bus.aux_req;
    forced   = contend & (wait_cnt == LIMIT);
    aux_own  = bus.aux_req & (~bus.core_en | forced);
    sel_we   = 4'h0;
    sel_addr = bus.core_addr;
    sel_din  = bus.core_din;
    if (aux_own) begin
      sel_we   = bus.aux_we;
      sel_addr = bus.aux_addr;
      sel_din  = bus.aux_din;
    end else if (bus.core_en) begin
      sel_we   = bus.core_we;
    end
    rd_issue = (bus.core_en | bus.aux_req) & (sel_we == 4'h0);
  end

  assign bus.ram_en      = bus.core_en | bus.aux_req;
  assign bus.ram_we      = sel_we;
  assign bus.ram_addr    = sel_addr;
  assign bus.ram_din     = sel_din;
  assign bus.aux_gnt     = aux_own;
  assign bus.core_stall  = bus.core_en & aux_own;

  assign aux_rvalid      = rd_pend & rd_owner;
  assign bus.aux_rvalid  = aux_rvalid;
  assign bus.core_rvalid = rd_pend & ~rd_owner;
  // Show live RAM data in the valid cycle, the captured word afterwards.
  assign bus.aux_rdata   = aux_rvalid ? bus.ram_dout : aux_rdata_hold;

  // Starvation counter: counts blocked contention cycles, clears on any
  // aux grant or when aux stops requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!bus.aux_req || aux_own) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read tracking: remember that a read was issued and by whom.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= rd_issue;
      rd_owner <= aux_own;
    end
  end

  // Capture aux read data at the end of its valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      aux_rdata_hold <= '0;
    end else if (aux_rvalid) begin
      aux_rdata_hold <= bus.ram_dout;
    end
  end

endmodule
